hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 28 ++
 rtl/hazard_ctrl_fwd_sel.sv | 41 ++++
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } hz_state_e;

  // Register write-back view of one pipeline stage
  typedef struct packed {
    logic                 we;
    logic [REG_IDX_W-1:0] wr;
    logic [XLEN-1:0]      wd;
  } wb_port_t;

  function automatic logic reg_hit(input logic                 used,
                                   input logic [REG_IDX_W-1:0] rs,
                                   input wb_port_t             p);
    return used && p.we && (p.wr == rs) && (p.wr != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forwarding select: EX > MEM > WB priority match and data mux.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs_i,
  input  logic                 rs_used_i,
  input  wb_port_t             ex_i,
  input  wb_port_t             mem_i,
  input  wb_port_t             wb_i,
  input  logic                 ex_is_load_i,
  output logic                 ex_hit_o,
  output logic                 fwd_o,
  output logic [XLEN-1:0]      data_o
);

  logic mem_hit;
  logic wb_hit;

  assign ex_hit_o = reg_hit(rs_used_i, rs_i, ex_i);
  assign mem_hit  = reg_hit(rs_used_i, rs_i, mem_i);
  assign wb_hit   = reg_hit(rs_used_i, rs_i, wb_i);

  // An EX load hit shadows older stages: their value is stale, and the load data isn't ready
  always_comb begin
    fwd_o  = 1'b0;
    data_o = '0;
    if (ex_hit_o) begin
      if (!ex_is_load_i) begin
        fwd_o  = 1'b1;
        data_o = ex_i.wd;
      end
    end else if (mem_hit) begin
      fwd_o  = 1'b1;
      data_o = mem_i.wd;
    end else if (wb_hit) begin
      fwd_o  = 1'b1;
      data_o = wb_i.wd;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush
// and saturating stall/flush event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYC = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_IDX_W-1:0] ex_wR,
  input  logic [REG_IDX_W-1:0] mem_wR,
  input  logic [REG_IDX_W-1:0] wb_wR,
  input  logic                 ex_rf_we,
  input  logic                 mem_rf_we,
  input  logic                 wb_rf_we,
  input  logic                 ex_is_load,
  input  logic [XLEN-1:0]      ex_wD,
  input  logic [XLEN-1:0]      mem_wD,
  input  logic [XLEN-1:0]      wb_wD,
  input  logic                 branch_taken,
  output logic                 forward_op1,
  output logic                 forward_op2,
  output logic [XLEN-1:0]      rD1_forward,
  output logic [XLEN-1:0]      rD2_forward,
  output logic                 pc_stall,
  output logic                 ifid_stall,
  output logic                 idex_flush,
  output logic                 ifid_flush,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam int unsigned SC_W = 2;

  hz_state_e        state_q, state_d;
  logic [SC_W-1:0]  scnt_q, scnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  wb_port_t        ex_p, mem_p, wb_p;
  logic            ex_hit1, ex_hit2;
  logic            fwd1, fwd2;
  logic [XLEN-1:0] data1, data2;
  logic            load_use;

  assign ex_p  = '{we: ex_rf_we,  wr: ex_wR,  wd: ex_wD};
  assign mem_p = '{we: mem_rf_we, wr: mem_wR, wd: mem_wD};
  assign wb_p  = '{we: wb_rf_we,  wr: wb_wR,  wd: wb_wD};

  fwd_sel u_fwd_op1 (
    .rs_i         (id_rs1),
    .rs_used_i    (id_rs1_used),
    .ex_i         (ex_p),
    .mem_i        (mem_p),
    .wb_i         (wb_p),
    .ex_is_load_i (ex_is_load),
    .ex_hit_o     (ex_hit1),
    .fwd_o        (fwd1),
    .data_o       (data1)
  );

  fwd_sel u_fwd_op2 (
    .rs_i         (id_rs2),
    .rs_used_i    (id_rs2_used),
    .ex_i         (ex_p),
    .mem_i        (mem_p),
    .wb_i         (wb_p),
    .ex_is_load_i (ex_is_load),
    .ex_hit_o     (ex_hit2),
    .fwd_o        (fwd2),
    .data_o       (data2)
  );

  assign load_use = ex_is_load && (ex_hit1 || ex_hit2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      scnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Detection cycle is the first bubble; STALL supplies the remaining LOAD_STALL_CYC-1
  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    idex_flush = 1'b0;
    ifid_flush = 1'b0;
    if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      scnt_d     = '0;
      state_d    = ST_FLUSH;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            scnt_d     = SC_W'(LOAD_STALL_CYC - 1);
            if (scnt_d != '0) state_d = ST_STALL;
          end
        end
        ST_STALL: begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          if (scnt_q <= SC_W'(1)) begin
            scnt_d  = '0;
            state_d = ST_RUN;
          end else begin
            scnt_d = scnt_q - SC_W'(1);
          end
        end
        ST_FLUSH: begin
          idex_flush = 1'b1;
          state_d    = ST_RUN;
        end
        default: begin
          scnt_d  = '0;
          state_d = ST_RUN;
        end
      endcase
    end
    if (!rst_n) begin
      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
      idex_flush = 1'b0;
      ifid_flush = 1'b0;
    end
  end

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && !(&stall_cnt_q))     stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (branch_taken && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign forward_op1 = fwd1 && !pc_stall;
  assign forward_op2 = fwd2 && !pc_stall;
  assign rD1_forward = pc_stall ? '0 : data1;
  assign rD2_forward = pc_stall ? '0 : data2;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (LOAD_STALL_CYC=2, CNT_W=4).
module tb_hazard_ctrl;

  localparam int unsigned LSC = 2;
  localparam int unsigned CW  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_wR, mem_wR, wb_wR;
  logic        id_rs1_used, id_rs2_used;
  logic        ex_rf_we, mem_rf_we, wb_rf_we, ex_is_load, branch_taken;
  logic [31:0] ex_wD, mem_wD, wb_wD;
  logic        forward_op1, forward_op2, pc_stall, ifid_stall, idex_flush, ifid_flush;
  logic [31:0] rD1_forward, rD2_forward;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYC(LSC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_wR(ex_wR), .mem_wR(mem_wR), .wb_wR(wb_wR),
    .ex_rf_we(ex_rf_we), .mem_rf_we(mem_rf_we), .wb_rf_we(wb_rf_we),
    .ex_is_load(ex_is_load), .ex_wD(ex_wD), .mem_wD(mem_wD), .wb_wD(wb_wD),
    .branch_taken(branch_taken),
    .forward_op1(forward_op1), .forward_op2(forward_op2),
    .rD1_forward(rD1_forward), .rD2_forward(rD2_forward),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .idex_flush(idex_flush), .ifid_flush(ifid_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {fwd1, rD1, fwd2, rD2, pc_stall, ifid_stall, idex_flush, ifid_flush}
  typedef struct packed {
    logic        f1;
    logic [31:0] d1;
    logic        f2;
    logic [31:0] d2;
    logic        ps;
    logic        is;
    logic        xf;
    logic        ff;
  } vec_t;

  vec_t  exp_q[$];
  vec_t  obs_q[$];
  string tag_q[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic vec_t mk(input logic f1, input logic [31:0] d1,
                              input logic f2, input logic [31:0] d2,
                              input logic ps, input logic is,
                              input logic xf, input logic ff);
    vec_t v;
    v = '{f1: f1, d1: d1, f2: f2, d2: d2, ps: ps, is: is, xf: xf, ff: ff};
    return v;
  endfunction

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_wR = '0; mem_wR = '0; wb_wR = '0;
    ex_rf_we = 1'b0; mem_rf_we = 1'b0; wb_rf_we = 1'b0;
    ex_is_load = 1'b0; branch_taken = 1'b0;
    ex_wD = '0; mem_wD = '0; wb_wD = '0;
  endtask

  // Inputs already applied at a falling edge: record expectation and observation
  task automatic tick(input string tag, input vec_t e);
    #1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    obs_q.push_back({forward_op1, rD1_forward, forward_op2, rD2_forward,
                     pc_stall, ifid_stall, idex_flush, ifid_flush});
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_load_use();
    ex_is_load = 1'b1; ex_rf_we = 1'b1; ex_wR = 5'd7; ex_wD = 32'h99;
    id_rs1 = 5'd7; id_rs1_used = 1'b1;
  endtask

  task automatic test_reset();
    vec_t e, o; string t;
    rst_n = 1'b0;
    clear_inputs();
    set_load_use();
    branch_taken = 1'b1;
    id_rs2 = 5'd4; id_rs2_used = 1'b1; mem_rf_we = 1'b1; mem_wR = 5'd4; mem_wD = 32'hAB;
    tick("reset_outputs", mk(0, 0, 1, 32'hAB, 0, 0, 0, 0));
    checks++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_counters: stall_cnt=%0d flush_cnt=%0d expected 0/0", stall_cnt, flush_cnt);
    end
    clear_inputs();
    rst_n = 1'b1;
    tick("post_reset_idle", mk(0, 0, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_forward();
    vec_t e, o; string t;
    clear_inputs();
    id_rs1 = 5'd5; id_rs1_used = 1'b1; id_rs2 = 5'd6; id_rs2_used = 1'b1;
    ex_rf_we = 1'b1; ex_wR = 5'd5; ex_wD = 32'h11;
    mem_rf_we = 1'b1; mem_wR = 5'd5; mem_wD = 32'h22;
    tick("fwd_ex_over_mem", mk(1, 32'h11, 0, 0, 0, 0, 0, 0));
    ex_rf_we = 1'b0;
    tick("fwd_mem_when_ex_no_we", mk(1, 32'h22, 0, 0, 0, 0, 0, 0));
    ex_rf_we = 1'b1; id_rs1_used = 1'b0;
    tick("fwd_operand_unused", mk(0, 0, 0, 0, 0, 0, 0, 0));
    clear_inputs();
    id_rs1_used = 1'b1; id_rs2_used = 1'b1;
    ex_rf_we = 1'b1; mem_rf_we = 1'b1; wb_rf_we = 1'b1;
    ex_wD = 32'h1; mem_wD = 32'h2; wb_wD = 32'h3;
    tick("fwd_x0_never", mk(0, 0, 0, 0, 0, 0, 0, 0));
    clear_inputs();
    id_rs1 = 5'd3; id_rs1_used = 1'b1; id_rs2 = 5'd9; id_rs2_used = 1'b1;
    ex_wR = 5'd3; ex_wD = 32'h77;
    mem_rf_we = 1'b1; mem_wR = 5'd3; mem_wD = 32'h44;
    wb_rf_we = 1'b1; wb_wR = 5'd9; wb_wD = 32'h33;
    tick("fwd_mem_and_wb", mk(1, 32'h44, 1, 32'h33, 0, 0, 0, 0));
    clear_inputs();
    id_rs1 = 5'd12; id_rs2 = 5'd12; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
    ex_rf_we = 1'b1; ex_wR = 5'd12; ex_wD = 32'hCAFE;
    mem_rf_we = 1'b1; mem_wR = 5'd12; mem_wD = 32'h1;
    wb_rf_we = 1'b1; wb_wR = 5'd12; wb_wD = 32'h2;
    tick("fwd_ex_both_ops", mk(1, 32'hCAFE, 1, 32'hCAFE, 0, 0, 0, 0));
    clear_inputs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_load_use();
    vec_t e, o; string t;
    apply_reset();
    set_load_use();
    id_rs2 = 5'd8; id_rs2_used = 1'b1; mem_rf_we = 1'b1; mem_wR = 5'd8; mem_wD = 32'h55;
    tick("lu_detect", mk(0, 0, 0, 0, 1, 1, 1, 0));
    ex_is_load = 1'b0; ex_rf_we = 1'b0;
    tick("lu_stall2", mk(0, 0, 0, 0, 1, 1, 1, 0));
    tick("lu_resume", mk(0, 0, 1, 32'h55, 0, 0, 0, 0));
    clear_inputs();
    tick("lu_idle", mk(0, 0, 0, 0, 0, 0, 0, 0));
    checks++;
    if (stall_cnt !== 4'd2) begin
      failures++; $display("FAIL lu_stall_cnt: got %0d expected 2", stall_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_branch_priority();
    vec_t e, o; string t;
    apply_reset();
    set_load_use();
    branch_taken = 1'b1;
    tick("br_over_lu", mk(0, 0, 0, 0, 0, 0, 1, 1));
    clear_inputs();
    tick("br_flush_state", mk(0, 0, 0, 0, 0, 0, 1, 0));
    tick("br_back_to_run", mk(0, 0, 0, 0, 0, 0, 0, 0));
    checks++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      failures++;
      $display("FAIL br_counters: flush_cnt=%0d stall_cnt=%0d expected 1/0", flush_cnt, stall_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_back_to_back();
    vec_t e, o; string t;
    branch_taken = 1'b1;
    tick("b2b_br1", mk(0, 0, 0, 0, 0, 0, 1, 1));
    tick("b2b_br2_in_flush", mk(0, 0, 0, 0, 0, 0, 1, 1));
    branch_taken = 1'b0;
    tick("b2b_flush", mk(0, 0, 0, 0, 0, 0, 1, 0));
    tick("b2b_run", mk(0, 0, 0, 0, 0, 0, 0, 0));
    checks++;
    if (flush_cnt !== 4'd3) begin
      failures++; $display("FAIL b2b_flush_cnt: got %0d expected 3", flush_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_stall_abort();
    vec_t e, o; string t;
    apply_reset();
    set_load_use();
    tick("abort_detect", mk(0, 0, 0, 0, 1, 1, 1, 0));
    clear_inputs();
    branch_taken = 1'b1;
    tick("abort_branch_in_stall", mk(0, 0, 0, 0, 0, 0, 1, 1));
    branch_taken = 1'b0;
    tick("abort_flush", mk(0, 0, 0, 0, 0, 0, 1, 0));
    tick("abort_run", mk(0, 0, 0, 0, 0, 0, 0, 0));
    tick("abort_no_residual", mk(0, 0, 0, 0, 0, 0, 0, 0));
    checks++;
    if (stall_cnt !== 4'd1 || flush_cnt !== 4'd1) begin
      failures++;
      $display("FAIL abort_counters: stall_cnt=%0d flush_cnt=%0d expected 1/1", stall_cnt, flush_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_saturation();
    vec_t e, o; string t;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      set_load_use();
      tick("sat_detect", mk(0, 0, 0, 0, 1, 1, 1, 0));
      clear_inputs();
      tick("sat_stall", mk(0, 0, 0, 0, 1, 1, 1, 0));
    end
    tick("sat_idle", mk(0, 0, 0, 0, 0, 0, 0, 0));
    checks++;
    if (stall_cnt !== 4'hF) begin
      failures++; $display("FAIL sat_stall_cnt: got %h expected f", stall_cnt);
    end
    branch_taken = 1'b1;
    for (int i = 0; i < 18; i++) tick("sat_branch", mk(0, 0, 0, 0, 0, 0, 1, 1));
    branch_taken = 1'b0;
    tick("sat_flush", mk(0, 0, 0, 0, 0, 0, 1, 0));
    checks++;
    if (flush_cnt !== 4'hF) begin
      failures++; $display("FAIL sat_flush_cnt: got %h expected f", flush_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  task automatic test_reset_mid();
    vec_t e, o; string t;
    set_load_use();
    tick("rmid_detect", mk(0, 0, 0, 0, 1, 1, 1, 0));
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      failures++;
      $display("FAIL rmid_counters: stall_cnt=%0d flush_cnt=%0d expected 0/0", stall_cnt, flush_cnt);
    end
    tick("rmid_stall_aborted", mk(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    tick("rmid_no_bubble", mk(0, 0, 0, 0, 0, 0, 0, 0));
    branch_taken = 1'b1;
    tick("rmid_branch", mk(0, 0, 0, 0, 0, 0, 1, 1));
    branch_taken = 1'b0;
    rst_n = 1'b0;
    tick("rmid_flush_aborted", mk(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    tick("rmid_flush_no_residual", mk(0, 0, 0, 0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL %s: got %h expected %h", t, o, e); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_forward();
    test_load_use();
    test_branch_priority();
    test_back_to_back();
    test_stall_abort();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
